// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl
//   Register-dump sequencer. It sits beside the CPU and drives the CPU debug
//   read port. A start pulse makes it step reg_sel through 0..NUM_REGS-1 and
//   capture each reg_data word. Each word then goes out as DATA_W/8 bytes,
//   most significant byte first, towards the board UART transmitter.
//
// Ports
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   start      in   begin a dump; only looked at while idle
//   busy       out  high from the cycle after start is accepted through DONE
//   done       out  one-cycle pulse when the last byte has been sent
//   reg_sel    out  register index presented to the CPU debug port
//   reg_data   in   register contents returned by the CPU
//   tx_data    out  byte currently offered downstream
//   tx_valid   out  tx_data holds a byte that has not yet been taken
//   tx_ready   in   downstream can take the byte this cycle
//   dbg_state  out  current FSM state (IDLE=0, SEL=1, SEND=2, DONE=3)
//
// Handshake: a byte moves on a rising edge where tx_valid && tx_ready.
// Once tx_valid is high, tx_data and tx_valid stay unchanged until that
// edge, however long tx_ready stays low. tx_valid never depends on tx_ready.

module reg_dump_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int SEL_W    = 5,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [1:0]        dbg_state
);

  localparam int NB   = DATA_W / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(NB - 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_REGS - 1);
  localparam logic [2:0]       LAT       = 3'(READ_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_index;
  logic [SEL_W-1:0]  w_index_nxt;
  logic [2:0]        r_wait;
  logic [2:0]        w_wait_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BC_W-1:0]   r_byte;
  logic [BC_W-1:0]   w_byte_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_index <= '0;
      r_wait  <= '0;
      r_shift <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_wait  <= w_wait_nxt;
      r_shift <= w_shift_nxt;
      r_byte  <= w_byte_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_wait_nxt  = r_wait;
    w_shift_nxt = r_shift;
    w_byte_nxt  = r_byte;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SEL;
          w_index_nxt = '0;
          w_wait_nxt  = '0;
        end
      end
      ST_SEL: begin
        // reg_sel has been stable for READ_LAT+1 cycles once r_wait
        // reaches LAT, so reg_data is valid at this edge.
        if (r_wait == LAT) begin
          w_shift_nxt = reg_data;
          w_byte_nxt  = '0;
          w_state_nxt = ST_SEND;
        end else begin
          w_wait_nxt = r_wait + 3'd1;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          // The top byte of the shift register is always the byte on
          // offer, so shifting by one byte presents the next one.
          w_shift_nxt = r_shift << 8;
          if (r_byte == LAST_BYTE) begin
            w_wait_nxt = '0;
            // Compare against the last index explicitly so that a full
            // 2^SEL_W sweep stops instead of wrapping back to 0.
            if (r_index == LAST_IDX) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_index_nxt = r_index + SEL_W'(1);
              w_state_nxt = ST_SEL;
            end
          end else begin
            w_byte_nxt = r_byte + BC_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign tx_valid  = (r_state == ST_SEND);
  assign tx_data   = r_shift[DATA_W-1 -: 8];
  assign reg_sel   = r_index;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
module tb_reg_dump_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int   which    = 0;
  logic start    = 1'b0;
  logic tx_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // instance 0: default parameters, zero-latency CPU model
  logic        start0, busy0, done0, txv0;
  logic [4:0]  sel0;
  logic [31:0] rd0;
  logic [7:0]  txd0;
  logic [1:0]  st0;
  // instance 1: READ_LAT=2, CPU model delays data by two cycles
  logic        start1, busy1, done1, txv1;
  logic [4:0]  sel1;
  logic [31:0] rd1;
  logic [7:0]  txd1;
  logic [1:0]  st1;
  logic [4:0]  sel1_d1 = '0;
  logic [4:0]  sel1_d2 = '0;
  // instance 2: NUM_REGS=4, SEL_W=2
  logic        start2, busy2, done2, txv2;
  logic [1:0]  sel2;
  logic [31:0] rd2;
  logic [7:0]  txd2;
  logic [1:0]  st2;

  assign start0 = start && (which == 0);
  assign start1 = start && (which == 1);
  assign start2 = start && (which == 2);

  assign rd0 = 32'h1000_0000 + 32'(sel0);
  always @(posedge clk) begin
    sel1_d1 <= sel1;
    sel1_d2 <= sel1_d1;
  end
  assign rd1 = 32'h2000_0000 + 32'(sel1_d2) * 32'h0000_0101;
  assign rd2 = 32'h1000_0000 + 32'(sel2);

  reg_dump_ctrl dut0 (
    .clk(clk), .rstn(rstn), .start(start0), .busy(busy0), .done(done0),
    .reg_sel(sel0), .reg_data(rd0), .tx_data(txd0), .tx_valid(txv0),
    .tx_ready(tx_ready), .dbg_state(st0)
  );

  reg_dump_ctrl #(.READ_LAT(2)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .busy(busy1), .done(done1),
    .reg_sel(sel1), .reg_data(rd1), .tx_data(txd1), .tx_valid(txv1),
    .tx_ready(tx_ready), .dbg_state(st1)
  );

  reg_dump_ctrl #(.NUM_REGS(4), .SEL_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .busy(busy2), .done(done2),
    .reg_sel(sel2), .reg_data(rd2), .tx_data(txd2), .tx_valid(txv2),
    .tx_ready(tx_ready), .dbg_state(st2)
  );

  // view of the instance under test
  logic       m_busy, m_done, m_valid;
  logic [7:0] m_data;
  logic [4:0] m_sel;
  always_comb begin
    m_busy  = busy0;
    m_done  = done0;
    m_valid = txv0;
    m_data  = txd0;
    m_sel   = sel0;
    if (which == 1) begin
      m_busy  = busy1;
      m_done  = done1;
      m_valid = txv1;
      m_data  = txd1;
      m_sel   = sel1;
    end else if (which == 2) begin
      m_busy  = busy2;
      m_done  = done2;
      m_valid = txv2;
      m_data  = txd2;
      m_sel   = {3'b000, sel2};
    end
  end

  function automatic logic [31:0] exp_word(input int w, input int r);
    if (w == 1) return 32'h2000_0000 + 32'(r) * 32'h0000_0101;
    return 32'h1000_0000 + 32'(r);
  endfunction

  function automatic int exp_nregs(input int w);
    return (w == 2) ? 4 : 32;
  endfunction

  function automatic int exp_lat(input int w);
    return (w == 1) ? 2 : 0;
  endfunction

  // byte monitor and handshake checks, sampled on the falling edge
  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = '0;
  logic [4:0] prev_sel   = '0;
  int         sel_run    = 0;

  always @(negedge clk) begin
    if (prev_stall) begin
      n_vec++;
      if (m_valid !== 1'b1 || m_data !== prev_data) begin
        n_err++;
        $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                 m_valid, m_data, prev_data);
      end
    end
    if (prev_valid && m_valid) begin
      n_vec++;
      if (m_sel !== prev_sel) begin
        n_err++;
        $display("FAIL sel_stable_in_send: reg_sel=%0d, required %0d", m_sel, prev_sel);
      end
    end
    if (m_valid && !prev_valid) begin
      n_vec++;
      if (sel_run != exp_lat(which) + 1) begin
        n_err++;
        $display("FAIL sel_hold_cycles: %0d, required %0d", sel_run, exp_lat(which) + 1);
      end
    end
    if (m_valid && tx_ready) got_q.push_back(m_data);
    if (m_busy && !m_valid && !m_done) sel_run++;
    else sel_run = 0;
    prev_stall = m_valid && !tx_ready;
    prev_valid = m_valid;
    prev_data  = m_data;
    prev_sel   = m_sel;
  end

  // Runs one dump on instance w and scores the byte stream.
  // exp_cyc > 0 enables per-cycle busy/done checks against that done cycle.
  task automatic do_dump(input int w, input bit rnd, input int restart_at, input int exp_cyc);
    int  n;
    int  done_cyc;
    int  done_cnt;
    bit  fin;
    logic [31:0] word;
    which = w;
    got_q.delete();
    exp_q.delete();
    for (int r = 0; r < exp_nregs(w); r++) begin
      word = exp_word(w, r);
      for (int b = 3; b >= 0; b--) exp_q.push_back(word[b*8 +: 8]);
    end
    n        = 0;
    done_cyc = 0;
    done_cnt = 0;
    fin      = 1'b0;
    start    = 1'b1;
    while (!fin && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      start    = (n == restart_at);
      tx_ready = rnd ? ($urandom_range(0, 99) < 40) : 1'b1;
      @(negedge clk);
      if (exp_cyc > 0) begin
        n_vec++;
        if (m_busy !== 1'(n <= exp_cyc)) begin
          n_err++;
          $display("FAIL busy_cycle%0d: busy=%b, required %b", n, m_busy, (n <= exp_cyc));
        end
        n_vec++;
        if (m_done !== 1'(n == exp_cyc)) begin
          n_err++;
          $display("FAIL done_cycle%0d: done=%b, required %b", n, m_done, (n == exp_cyc));
        end
      end
      if (done_cyc != 0 && n == done_cyc + 1) begin
        fin = 1'b1;
        n_vec++;
        if (m_busy !== 1'b0) begin
          n_err++;
          $display("FAIL busy_after_done: busy=%b, required 0", m_busy);
        end
      end
      if (m_done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    n_vec++;
    if (!fin) begin
      n_err++;
      $display("FAIL dump_timeout: inst %0d no done after %0d cycles, required done", w, n);
    end
    if (exp_cyc > 0) begin
      n_vec++;
      if (done_cyc != exp_cyc) begin
        n_err++;
        $display("FAIL done_latency: inst %0d cycle %0d, required %0d", w, done_cyc, exp_cyc);
      end
    end
    n_vec++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL done_pulses: inst %0d count %0d, required 1", w, done_cnt);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL byte_count: inst %0d got %0d, required %0d", w, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL byte%0d: inst %0d got %h, required %h", i, w, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if ({busy0, done0, txv0, sel0, txd0, st0} !== '0) begin
      n_err++;
      $display("FAIL reset_inst0: busy=%b done=%b valid=%b sel=%h data=%h st=%h, required all 0",
               busy0, done0, txv0, sel0, txd0, st0);
    end
    n_vec++;
    if ({busy1, done1, txv1, sel1, txd1, st1} !== '0) begin
      n_err++;
      $display("FAIL reset_inst1: busy=%b done=%b valid=%b sel=%h data=%h st=%h, required all 0",
               busy1, done1, txv1, sel1, txd1, st1);
    end
    n_vec++;
    if ({busy2, done2, txv2, sel2, txd2, st2} !== '0) begin
      n_err++;
      $display("FAIL reset_inst2: busy=%b done=%b valid=%b sel=%h data=%h st=%h, required all 0",
               busy2, done2, txv2, sel2, txd2, st2);
    end
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_dump(0, 1'b0, -1, 161);
  endtask

  task automatic test_random_ready();
    do_dump(0, 1'b1, -1, 0);
  endtask

  task automatic test_read_latency();
    do_dump(1, 1'b0, -1, 225);
  endtask

  task automatic test_start_while_busy();
    do_dump(0, 1'b0, 50, 161);
  endtask

  task automatic test_back_to_back();
    do_dump(0, 1'b0, -1, 161);
  endtask

  task automatic test_reset_mid_dump();
    bit found;
    int bad;
    which = 0;
    found = 1'b0;
    tx_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(negedge clk);
      if (m_valid === 1'b1 && m_sel == 5'd12) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL reach_reg12: not reached, required SEND of register 12");
    end
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if ({txv0, busy0, done0, sel0} !== '0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b busy=%b done=%b sel=%0d, required all 0",
               txv0, busy0, done0, sel0);
    end
    @(posedge clk);
    #3 rstn = 1'b1;
    got_q.delete();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || m_busy !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0 || got_q.size() != 0) begin
      n_err++;
      $display("FAIL quiet_after_reset: %0d active cycles, %0d bytes, required 0 and 0",
               bad, got_q.size());
    end
    do_dump(0, 1'b0, -1, 161);
  endtask

  task automatic test_small_full_range();
    int bad;
    int sz;
    do_dump(2, 1'b0, -1, 21);
    sz = got_q.size();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0 || got_q.size() != sz) begin
      n_err++;
      $display("FAIL no_wrap: %0d active cycles, %0d extra bytes, required 0 and 0",
               bad, got_q.size() - sz);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready();
    test_read_latency();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_dump();
    test_small_full_range();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
